// File: rtl/vec_alu_mc.sv
// Multi-cycle vector ALU: VADD/VDOT/SMUL walk the lanes in chunks, scalar ops resolve in one cycle.
// Valid/ready on both sides; one operation in flight, result held until the consumer takes it.
module vec_alu_mc #(
    parameter int unsigned LANES           = 16,
    parameter int unsigned LANE_W          = 16,
    parameter int unsigned LANES_PER_CYCLE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                opcode,
    input  logic [LANES*LANE_W-1:0]   op_1,
    input  logic [LANES*LANE_W-1:0]   op_2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   result,
    output logic                      illegal
);

    localparam int unsigned VW      = LANES * LANE_W;
    localparam int unsigned N_CHUNK = LANES / LANES_PER_CYCLE;
    localparam int unsigned K_W     = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int unsigned HALF    = LANE_W / 2;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [VW-1:0]      r_a;
    logic [VW-1:0]      r_b;
    logic [K_W-1:0]     r_k;
    logic [LANE_W-1:0]  r_acc;
    logic [VW-1:0]      r_result;
    logic               r_illegal;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [LANE_W-1:0]  w_a_lane    [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  w_b_lane    [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  w_sum_lane  [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  w_smul_lane [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  w_chunk_sum;
    logic [LANE_W-1:0]  w_a0;
    logic [LANE_W-1:0]  w_b0;
    logic [VW-1:0]      w_final;
    logic               w_illegal;
    logic               w_is_multi;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign illegal   = r_illegal;

    assign w_a0 = r_a[LANE_W-1:0];
    assign w_b0 = r_b[LANE_W-1:0];
    assign w_is_multi = (opcode == OP_VADD) || (opcode == OP_VDOT) || (opcode == OP_SMUL);

    // Per-chunk lane arithmetic on the latched operands, lanes [k*LPC, (k+1)*LPC)
    always_comb begin
        w_chunk_sum = '0;
        for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
            w_a_lane[j]    = r_a[(32'(r_k) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W];
            w_b_lane[j]    = r_b[(32'(r_k) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W];
            w_sum_lane[j]  = w_a_lane[j] + w_b_lane[j];
            w_smul_lane[j] = LANE_W'(w_a_lane[j] * w_b0);
            w_chunk_sum    = w_chunk_sum + LANE_W'(w_a_lane[j] * w_b_lane[j]);
        end
    end

    // Final result selection; vector ops have already filled r_result / r_acc
    always_comb begin
        w_final   = '0;
        w_illegal = 1'b0;
        case (r_op)
            OP_VADD, OP_SMUL: w_final = r_result;
            OP_VDOT:          w_final[LANE_W-1:0] = r_acc;
            OP_VLD, OP_VST:   w_final[LANE_W-1:0] = w_a0 + w_b0;
            OP_SLL:           w_final[LANE_W-1:0] = {w_a0[LANE_W-1:HALF], w_b0[HALF-1:0]};
            OP_SLH:           w_final[LANE_W-1:0] = {w_b0[HALF-1:0], w_a0[HALF-1:0]};
            OP_NOP:           w_final = '0;
            default:          w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= opcode;
                        r_a        <= op_1;
                        r_b        <= op_2;
                        r_k        <= '0;
                        r_acc      <= '0;
                        r_result   <= '0;
                        r_illegal  <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= w_is_multi ? S_EXEC : S_DONE;
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_VDOT) begin
                        r_acc <= r_acc + w_chunk_sum;
                    end else begin
                        for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
                            r_result[(32'(r_k) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W] <=
                                (r_op == OP_VADD) ? w_sum_lane[j] : w_smul_lane[j];
                        end
                    end
                    r_k <= r_k + K_W'(1);
                    if (r_k == K_W'(N_CHUNK - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; afterwards hold until taken
                    if (!r_out_valid) begin
                        r_result    <= w_final;
                        r_illegal   <= w_illegal;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_mc.sv
// Directed bench for vec_alu_mc at default parameters (16 lanes x 16 bits, 4 lanes/cycle).
module tb_vec_alu_mc;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned VW     = LANES * LANE_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [VW-1:0] op_1;
    logic [VW-1:0] op_2;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;
    logic          illegal;

    int n_vec = 0;
    int n_mis = 0;

    vec_alu_mc #(.LANES(16), .LANE_W(16), .LANES_PER_CYCLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op_1      (op_1),
        .op_2      (op_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one op, return cycles from accept edge to out_valid plus the captured result
    task automatic run_op(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic hold, output int lat,
                          output logic [VW-1:0] res, output logic ill);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("in_ready_before_accept", VW'(in_ready), VW'(1));
        in_valid  = 1'b1;
        opcode    = op;
        op_1      = a;
        op_2      = b;
        out_ready = ~hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_1     = ~a;
        op_2     = ~b;
        check("in_ready_after_accept", VW'(in_ready), VW'(0));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        ill = illegal;
    endtask

    logic [VW-1:0] a, b, e, res;
    logic          ill;
    int            lat;
    int            seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = 4'hF; op_1 = '0; op_2 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", VW'(in_ready), VW'(1));
        check("reset_out_valid", VW'(out_valid), VW'(0));
        check("reset_result", result, '0);
        check("reset_illegal", VW'(illegal), VW'(0));

        // VADD wrap: 0x7FFF + 1 in every lane
        for (int i = 0; i < 16; i++) begin
            a[i*16 +: 16] = 16'h7FFF;
            b[i*16 +: 16] = 16'h0001;
            e[i*16 +: 16] = 16'h8000;
        end
        run_op(4'b0000, a, b, 1'b0, lat, res, ill);
        check("vadd_latency", VW'(lat), VW'(5));
        check("vadd_result", res, e);
        check("vadd_illegal", VW'(ill), VW'(0));

        // VDOT: sum (i+1)*2 = 272
        for (int i = 0; i < 16; i++) begin
            a[i*16 +: 16] = 16'(i + 1);
            b[i*16 +: 16] = 16'h0002;
        end
        e = '0;
        e[15:0] = 16'h0110;
        run_op(4'b0001, a, b, 1'b0, lat, res, ill);
        check("vdot_latency", VW'(lat), VW'(5));
        check("vdot_result", res, e);

        // SMUL against b_0 only; other b lanes are decoys
        for (int i = 0; i < 16; i++) begin
            a[i*16 +: 16] = 16'h0100;
            b[i*16 +: 16] = 16'h5555;
            e[i*16 +: 16] = 16'h0100;
        end
        b[15:0] = 16'h0101;
        run_op(4'b0010, a, b, 1'b0, lat, res, ill);
        check("smul_latency", VW'(lat), VW'(5));
        check("smul_result", res, e);

        // SLL / SLH with junk in upper lanes, which must not leak into the result
        a = {VW/16{16'hFFFF}};
        b = {VW/16{16'hEEEE}};
        a[15:0] = 16'hABCD;
        b[15:0] = 16'h0012;
        e = '0;
        e[15:0] = 16'hAB12;
        run_op(4'b0110, a, b, 1'b0, lat, res, ill);
        check("sll_latency", VW'(lat), VW'(1));
        check("sll_result", res, e);
        a[15:0] = 16'hAB12;
        b[15:0] = 16'h0034;
        e[15:0] = 16'h3412;
        run_op(4'b0111, a, b, 1'b0, lat, res, ill);
        check("slh_latency", VW'(lat), VW'(1));
        check("slh_result", res, e);

        // NOP and a reserved opcode
        run_op(4'b1111, a, b, 1'b0, lat, res, ill);
        check("nop_result", res, '0);
        check("nop_illegal", VW'(ill), VW'(0));
        run_op(4'b1010, a, b, 1'b0, lat, res, ill);
        check("rsv_latency", VW'(lat), VW'(1));
        check("rsv_result", res, '0);
        check("rsv_illegal", VW'(ill), VW'(1));

        // J with consumer stall; a VADD offered meanwhile must be ignored
        run_op(4'b1000, a, b, 1'b1, lat, res, ill);
        check("j_latency", VW'(lat), VW'(1));
        check("j_result", res, '0);
        check("j_illegal", VW'(ill), VW'(1));
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            opcode   = 4'b0000;
            op_1     = {VW/16{16'h1234}};
            op_2     = {VW/16{16'h1111}};
            @(posedge clk); #1;
            check("stall_out_valid", VW'(out_valid), VW'(1));
            check("stall_result", result, '0);
            check("stall_illegal", VW'(illegal), VW'(1));
            check("stall_in_ready", VW'(in_ready), VW'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release_in_ready", VW'(in_ready), VW'(1));
        check("release_out_valid", VW'(out_valid), VW'(0));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("stalled_vadd_not_taken", VW'(seen), VW'(0));

        // Reset during the 2nd EXEC cycle of a VDOT
        in_valid = 1'b1;
        opcode   = 4'b0001;
        op_1     = {VW/16{16'h0003}};
        op_2     = {VW/16{16'h0004}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", VW'(in_ready), VW'(1));
        check("abort_out_valid", VW'(out_valid), VW'(0));
        check("abort_result", result, '0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", VW'(seen), VW'(0));

        // VLD address wrap
        a = '0;
        b = '0;
        a[15:0] = 16'hFFFF;
        b[15:0] = 16'h0002;
        e = '0;
        e[15:0] = 16'h0001;
        run_op(4'b0100, a, b, 1'b0, lat, res, ill);
        check("vld_latency", VW'(lat), VW'(1));
        check("vld_result", res, e);
        check("vld_illegal", VW'(ill), VW'(0));

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
